// File: rtl/sclk_gen_pkg.sv
// Shared types and default widths for the SPI serial-clock generator.
package sclk_gen_pkg;

    localparam int DEF_DIV_W = 8;
    localparam int DEF_CNT_W = 5;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LEAD = 2'd1,
        ST_RUN  = 2'd2,
        ST_TAIL = 2'd3
    } state_e;

endpackage

// File: rtl/sclk_gen_if.sv
// Control/status bundle of the serial-clock generator; slave is the generator side.
interface sclk_gen_if #(
    parameter int DIV_W = sclk_gen_pkg::DEF_DIV_W,
    parameter int CNT_W = sclk_gen_pkg::DEF_CNT_W
);
    logic             start;
    logic             abort;
    logic             cpol;
    logic             cpha;
    logic [DIV_W-1:0] div;
    logic [CNT_W-1:0] nbits;
    logic             busy;
    logic             sclk;
    logic             sample;
    logic             shift;
    logic             done;

    modport master (
        output start, abort, cpol, cpha, div, nbits,
        input  busy, sclk, sample, shift, done
    );

    modport slave (
        input  start, abort, cpol, cpha, div, nbits,
        output busy, sclk, sample, shift, done
    );
endinterface

// File: rtl/sclk_tick_cnt.sv
// Half-period counter: tick fires when the count reaches div, then wraps to zero.
module sclk_tick_cnt #(
    parameter int DIV_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             enable,
    input  logic [DIV_W-1:0] div,
    output logic             tick
);
    logic [DIV_W-1:0] cnt_q, cnt_d;

    assign tick = enable && (cnt_q == div);

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (enable) begin
            cnt_d = tick ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: rtl/sclk_gen.sv
// SPI clock generator: one half-period of setup, 2*nbits SCLK edges, one half-period of hold.
module sclk_gen
    import sclk_gen_pkg::*;
#(
    parameter int DIV_W = DEF_DIV_W,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic      clk,
    input  logic      rst_n,
    sclk_gen_if.slave bus
);
    state_e           state_q, state_d;
    logic             sclk_q, sclk_d;
    logic             busy_q, busy_d;
    logic             sample_q, sample_d;
    logic             shift_q, shift_d;
    logic             done_q, done_d;
    logic             cpol_q, cpol_d;
    logic             cpha_q, cpha_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [CNT_W-1:0] nbits_q, nbits_d;
    logic [CNT_W:0]   edge_q, edge_d, edge_inc;
    logic             tick, cnt_clear, cnt_enable, lead_edge, last_edge;

    sclk_tick_cnt #(.DIV_W(DIV_W)) u_tick (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (cnt_clear),
        .enable (cnt_enable),
        .div    (div_q),
        .tick   (tick)
    );

    // Holding the counter clear in IDLE guarantees it starts from 0 on entry to LEAD.
    assign cnt_clear  = (state_q == ST_IDLE);
    assign cnt_enable = (state_q != ST_IDLE);
    assign edge_inc   = edge_q + 1'b1;
    assign lead_edge  = ~edge_q[0];
    assign last_edge  = (edge_inc == {nbits_q, 1'b0});

    always_comb begin
        state_d  = state_q;
        sclk_d   = sclk_q;
        busy_d   = busy_q;
        sample_d = 1'b0;
        shift_d  = 1'b0;
        done_d   = 1'b0;
        cpol_d   = cpol_q;
        cpha_d   = cpha_q;
        div_d    = div_q;
        nbits_d  = nbits_q;
        edge_d   = edge_q;

        case (state_q)
            ST_IDLE: begin
                sclk_d = bus.cpol;
                busy_d = 1'b0;
                edge_d = '0;
                if (!bus.abort && bus.start && (bus.nbits != '0)) begin
                    cpol_d  = bus.cpol;
                    cpha_d  = bus.cpha;
                    div_d   = bus.div;
                    nbits_d = bus.nbits;
                    busy_d  = 1'b1;
                    state_d = ST_LEAD;
                end
            end
            ST_LEAD: begin
                if (tick) state_d = ST_RUN;
            end
            ST_RUN: begin
                if (tick) begin
                    sclk_d = ~sclk_q;
                    edge_d = edge_inc;
                    if (cpha_q) begin
                        shift_d  = lead_edge;
                        sample_d = ~lead_edge;
                    end else begin
                        sample_d = lead_edge;
                        shift_d  = ~lead_edge & ~last_edge;
                    end
                    if (last_edge) state_d = ST_TAIL;
                end
            end
            ST_TAIL: begin
                if (tick) begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if ((state_q != ST_IDLE) && bus.abort) begin
            state_d  = ST_IDLE;
            busy_d   = 1'b0;
            sclk_d   = bus.cpol;
            sample_d = 1'b0;
            shift_d  = 1'b0;
            done_d   = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            sclk_q   <= bus.cpol;
            busy_q   <= 1'b0;
            sample_q <= 1'b0;
            shift_q  <= 1'b0;
            done_q   <= 1'b0;
            cpol_q   <= 1'b0;
            cpha_q   <= 1'b0;
            div_q    <= '0;
            nbits_q  <= '0;
            edge_q   <= '0;
        end else begin
            state_q  <= state_d;
            sclk_q   <= sclk_d;
            busy_q   <= busy_d;
            sample_q <= sample_d;
            shift_q  <= shift_d;
            done_q   <= done_d;
            cpol_q   <= cpol_d;
            cpha_q   <= cpha_d;
            div_q    <= div_d;
            nbits_q  <= nbits_d;
            edge_q   <= edge_d;
        end
    end

    assign bus.busy   = busy_q;
    assign bus.sclk   = sclk_q;
    assign bus.sample = sample_q;
    assign bus.shift  = shift_q;
    assign bus.done   = done_q;
endmodule

// File: tb/tb_sclk_gen.sv
// Scoreboard bench for sclk_gen: expected transfer summaries are queued at start and checked when busy falls.
module tb_sclk_gen;
    localparam int DW = 8;
    localparam int CW = 5;

    typedef struct {
        int kind;        // 0 = normal completion, 1 = cut short by abort or reset
        int busy_len;
        int edges;
        int first_edge;
        int samp_r;
        int samp_f;
        int shift_r;
        int shift_f;
        int done;
        bit cpol;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   errors = 0;
    int   checks = 0;
    int   pops = 0;
    int   pushes = 0;
    exp_t sbq[$];

    sclk_gen_if #(.DIV_W(DW), .CNT_W(CW)) bus ();

    sclk_gen #(.DIV_W(DW), .CNT_W(CW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    // Monitor: accumulates per-transfer observations, compares on the busy falling cycle.
    int m_len, m_edges, m_first, m_sr, m_sf, m_hr, m_hf, m_orph, m_done;
    bit prev_busy = 1'b0;
    bit prev_sclk = 1'b0;

    always @(negedge clk) begin
        bit   chg;
        exp_t e;
        if (bus.busy && !prev_busy) begin
            m_len = 0; m_edges = 0; m_first = -1; m_sr = 0; m_sf = 0;
            m_hr = 0; m_hf = 0; m_orph = 0; m_done = 0;
        end
        if (bus.busy) begin
            chg = (bus.sclk != prev_sclk);
            if (chg) begin
                if (m_first < 0) m_first = m_len;
                m_edges++;
            end
            if (bus.sample) begin
                if (chg && bus.sclk) m_sr++;
                else if (chg) m_sf++;
                else m_orph++;
            end
            if (bus.shift) begin
                if (chg && bus.sclk) m_hr++;
                else if (chg) m_hf++;
                else m_orph++;
            end
            m_len++;
        end
        if (bus.done) m_done++;
        if (prev_busy && !bus.busy) begin
            pops++;
            chk("unexpected_xfer", (sbq.size() > 0) ? 1 : 0, 1);
            if (sbq.size() > 0) begin
                e = sbq.pop_front();
                $display("xfer %0d kind=%0d len=%0d edges=%0d first=%0d samp=%0d/%0d shift=%0d/%0d done=%0d",
                         pops, e.kind, m_len, m_edges, m_first, m_sr, m_sf, m_hr, m_hf, m_done);
                chk("edges", m_edges, e.edges);
                chk("done", m_done, e.done);
                if (e.kind == 0) begin
                    chk("busy_len", m_len, e.busy_len);
                    chk("first_edge", m_first, e.first_edge);
                    chk("sample_rise", m_sr, e.samp_r);
                    chk("sample_fall", m_sf, e.samp_f);
                    chk("shift_rise", m_hr, e.shift_r);
                    chk("shift_fall", m_hf, e.shift_f);
                    chk("orphan_pulse", m_orph, 0);
                end else begin
                    chk("cut_sclk", int'(bus.sclk), int'(e.cpol));
                    chk("cut_sample", int'(bus.sample), 0);
                    chk("cut_shift", int'(bus.shift), 0);
                end
            end
            m_edges = 0;
        end
        prev_busy = bus.busy;
        prev_sclk = bus.sclk;
    end

    task automatic wait_pop(input int budget);
        int p0;
        p0 = pops;
        for (int i = 0; i < budget && pops == p0; i++) @(posedge clk);
        chk("xfer_complete", pops - p0, 1);
    endtask

    task automatic configure(input bit pol, input bit pha, input int d, input int n);
        @(posedge clk); #1;
        bus.cpol  = pol;
        bus.cpha  = pha;
        bus.div   = d[DW-1:0];
        bus.nbits = n[CW-1:0];
        repeat (2) @(posedge clk);
    endtask

    task automatic pulse_start;
        #1 bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
    endtask

    task automatic run_xfer(input bit pol, input bit pha, input int d, input int n, input bit disturb);
        exp_t e;
        bit   lead_rise;
        int   nsh;
        lead_rise   = (pol == 1'b0);
        nsh         = pha ? n : n - 1;
        e.kind      = 0;
        e.busy_len  = (2 * n + 2) * (d + 1);
        e.edges     = 2 * n;
        e.first_edge = 2 * (d + 1);
        e.samp_r    = ((!pha) == lead_rise) ? n : 0;
        e.samp_f    = n - e.samp_r;
        e.shift_r   = (pha == lead_rise) ? nsh : 0;
        e.shift_f   = nsh - e.shift_r;
        e.done      = 1;
        e.cpol      = pol;
        configure(pol, pha, d, n);
        sbq.push_back(e);
        pushes++;
        pulse_start();
        if (disturb) begin
            repeat (4) @(posedge clk);
            #1;
            bus.start = 1'b1;
            bus.nbits = 5'd3;
            bus.div   = bus.div + 8'd1;
            bus.cpha  = ~pha;
            @(posedge clk); #1;
            bus.start = 1'b0;
        end
        wait_pop(e.busy_len + 40);
    endtask

    task automatic run_cut(input bit use_reset);
        exp_t e;
        e = '{kind: 1, busy_len: 0, edges: (use_reset ? 5 : 3), first_edge: 0,
              samp_r: 0, samp_f: 0, shift_r: 0, shift_f: 0, done: 0, cpol: 1'b1};
        configure(1'b1, 1'b0, 2, 8);
        sbq.push_back(e);
        pushes++;
        pulse_start();
        for (int i = 0; i < 200 && m_edges < e.edges; i++) @(posedge clk);
        #1;
        if (use_reset) rst_n = 1'b0;
        else           bus.abort = 1'b1;
        @(posedge clk); #1;
        rst_n     = 1'b1;
        bus.abort = 1'b0;
        wait_pop(40);
    endtask

    initial begin
        bus.start = 1'b0;
        bus.abort = 1'b0;
        bus.cpol  = 1'b1;
        bus.cpha  = 1'b0;
        bus.div   = '0;
        bus.nbits = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_sclk", int'(bus.sclk), 1);
        chk("rst_busy", int'(bus.busy), 0);
        chk("rst_sample", int'(bus.sample), 0);
        chk("rst_shift", int'(bus.shift), 0);
        chk("rst_done", int'(bus.done), 0);
        rst_n = 1'b1;

        // Idle SCLK tracks live cpol.
        @(posedge clk); #1 bus.cpol = 1'b0;
        repeat (2) @(negedge clk);
        chk("idle_sclk_cpol0", int'(bus.sclk), 0);

        // start with nbits=0 is ignored.
        @(posedge clk); #1 bus.nbits = '0;
        pulse_start();
        repeat (4) @(negedge clk);
        chk("nbits0_busy", int'(bus.busy), 0);
        chk("nbits0_sclk", int'(bus.sclk), 0);

        // abort beats start in IDLE.
        @(posedge clk); #1;
        bus.nbits = 5'd4;
        bus.abort = 1'b1;
        pulse_start();
        bus.abort = 1'b0;
        repeat (4) @(negedge clk);
        chk("abort_start_busy", int'(bus.busy), 0);

        run_xfer(1'b0, 1'b0, 0, 8, 1'b0);
        run_xfer(1'b1, 1'b1, 3, 4, 1'b0);
        run_xfer(1'b0, 1'b1, 255, 1, 1'b0);
        run_xfer(1'b1, 1'b0, 1, 5, 1'b1);
        run_cut(1'b0);
        run_xfer(1'b1, 1'b0, 2, 8, 1'b0);
        run_cut(1'b1);
        run_xfer(1'b0, 1'b0, 0, 31, 1'b0);
        run_xfer(1'b1, 1'b1, 0, 1, 1'b0);

        repeat (5) @(posedge clk);
        chk("sb_leftover", sbq.size(), 0);
        chk("xfer_count", pops, pushes);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
